res_arbiter: RTL
================

Name: res_arbiter

Overview:
Round-robin arbiter that shares one single-port resource among N_REQ requesters. The resource uses a valid/ready handshake: ready rises the cycle after valid is sampled, and stays high while valid stays high.
- Sits between HLS-generated requester threads and the resource instance.
- Serialises requests and returns a one-cycle ready pulse to the winning requester.
- Forces valid low between transactions so the resource re-arms for each new transaction.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, 2, width of grant index; must satisfy 2**ID_W >= N_REQ
CNT_W, 16, width of completed-transaction counter
TIMEOUT, 15, max cycles in BUSY waiting for res_ready (used only with RES_ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_valid  input  N_REQ  per-requester request; held high until own req_ready pulse
req_ready  output  N_REQ  per-requester completion pulse, one-hot or zero
res_valid  output  1  request to shared resource (registered)
res_ready  input  1  resource ready
grant_id  output  ID_W  index of current or last winner (registered)
busy  output  1  high when state != IDLE
xfer_count  output  CNT_W  completed transactions, wraps at 2**CNT_W
timeout_err  output  1  sticky timeout flag (tied 0 without macro)

Behaviour:
- Reset values:
  - state=IDLE, res_valid=0, req_ready=0, grant_id=0, rr_ptr=0, xfer_count=0, timeout_err=0.
  - rst asserted mid-transaction: every register returns to its reset value at the next edge. No req_ready pulse is issued for the interrupted transaction.
- States: IDLE, BUSY, RELEASE.
- Winner selection (the "pick"):
  - Winner is the first set bit of req_valid scanning upward from rr_ptr, with wrap-around modulo N_REQ.
  - A pick occurs in IDLE, and in RELEASE when res_ready==0.
  - Pick effect at the edge: grant_id<=winner, res_valid<=1, state<=BUSY.
- IDLE:
  - Any req_valid set → pick.
  - Otherwise stay in IDLE.
- BUSY:
  - res_valid=1.
  - res_ready==1 and req_valid[grant_id]==1 → handshake completes:
    - req_ready[grant_id]=1 combinationally in this cycle only.
    - At the edge: rr_ptr<=(grant_id+1) mod N_REQ, xfer_count<=xfer_count+1, res_valid<=0, state<=RELEASE.
  - req_valid[grant_id]==0 (requester withdrew) → abort:
    - No req_ready pulse, rr_ptr unchanged, counter unchanged.
    - res_valid<=0, state<=RELEASE.
  - Withdrawal and res_ready==1 in the same cycle → treated as abort.
- RELEASE:
  - res_valid=0.
  - Stay while res_ready==1.
  - When res_ready==0: pick if any req_valid set, else go to IDLE.
- Latency and throughput:
  - Request seen in IDLE at cycle 0 → res_valid=1 in cycle 1 → res_ready=1 in cycle 2 → req_ready pulse in cycle 2.
  - Back-to-back transaction period is 4 cycles: BUSY, BUSY, RELEASE, RELEASE.
- req_ready is never asserted outside BUSY and is at most one-hot.
- A requester that keeps req_valid high after its pulse is treated as a new request. Round-robin order still lets all others go first.
- req_valid bits at index >= N_REQ do not exist. grant_id values >= N_REQ never occur.

Optional Feature:
RES_ARB_TIMEOUT_EN:
- With the macro defined:
  - A wait counter clears on entry to BUSY and increments each BUSY cycle without a handshake.
  - When the counter reaches TIMEOUT: timeout_err<=1 (sticky until rst), abort exactly as for a withdrawal, rr_ptr<=(grant_id+1) mod N_REQ so a stuck grantee cannot starve others, and state<=RELEASE.
- Without the macro: no wait counter, BUSY waits indefinitely, timeout_err tied to 0.

Test Plan:
- Single requester: req_valid=4'b0001 at cycle 0 → res_valid=1 in cycle 1, req_ready=4'b0001 only in cycle 2, res_valid=0 in cycle 3, xfer_count=1.
- Contention: req_valid=4'b1111 held, each requester dropping its bit after its pulse → grant order 0,1,2,3, pulses 4 cycles apart, xfer_count=4, no overlapping req_ready.
- Fairness: requesters 0 and 2 held high continuously → grants alternate 0,2,0,2 and neither is granted twice in a row.
- Abort: req_valid[1] drops in first BUSY cycle → no req_ready, state returns to IDLE via RELEASE, xfer_count unchanged, rr_ptr unchanged.
- Reset mid-transaction: rst asserted while in BUSY → next cycle res_valid=0, busy=0, grant_id=0, xfer_count=0, no pulse.
- Timeout (macro on, TIMEOUT=15, res_ready tied 0, req_valid=4'b0011) → abort after 15 BUSY cycles, timeout_err=1, next grant is requester 1.

Source files
------------

// File: rtl/res_arbiter.sv
// res_arbiter: round-robin arbiter sharing one valid/ready resource.
// Optional RES_ARB_TIMEOUT_EN adds a BUSY wait timeout with sticky error.
module res_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count,
  output logic             timeout_err
);

  localparam int NP = 1 << ID_W;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] next_ptr;
  logic [NP-1:0]   req_pad;
  logic            any_req;
  logic            sel_valid;
  logic            to_hit;
  logic            do_pick;
  logic            do_done;
  logic            do_abort;
  logic            do_to;

  if ((1 << ID_W) < N_REQ || N_REQ < 2 || TIMEOUT < 1) begin : g_param_err
    $error("res_arbiter: bad parameters");
  end

  assign req_pad   = NP'(req_valid);
  assign sel_valid = req_pad[grant_id];
  assign busy      = (state_q != IDLE);
  assign next_ptr  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign req_ready = do_done ? (N_REQ'(1) << grant_id) : '0;

  // first requester at or above rr_ptr, wrapping modulo N_REQ
  always_comb begin
    int idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        winner  = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  // next state and per-cycle actions
  always_comb begin
    state_d  = state_q;
    do_pick  = 1'b0;
    do_done  = 1'b0;
    do_abort = 1'b0;
    do_to    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          do_pick = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!sel_valid) begin
          do_abort = 1'b1;
          state_d  = RELEASE;
        end else if (res_ready) begin
          do_done = 1'b1;
          state_d = RELEASE;
        end else if (to_hit) begin
          do_to   = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!res_ready) begin
          if (any_req) begin
            do_pick = 1'b1;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, grant, pointer, resource valid and transfer counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      res_valid  <= 1'b0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      xfer_count <= '0;
    end else begin
      state_q <= state_d;
      if (do_pick) begin
        grant_id  <= winner;
        res_valid <= 1'b1;
      end else if (do_done || do_abort || do_to) begin
        res_valid <= 1'b0;
      end
      if (do_done || do_to) begin
        rr_ptr <= next_ptr;
      end
      if (do_done) begin
        xfer_count <= xfer_count + 1'b1;
      end
    end
  end

`ifdef RES_ARB_TIMEOUT_EN
  localparam int WT_W = $clog2(TIMEOUT + 1);

  logic [WT_W-1:0] wait_cnt;

  assign to_hit = (state_q == BUSY) &&
                  (wait_cnt == WT_W'(TIMEOUT - 1));

  // BUSY wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (do_pick) begin
        wait_cnt <= '0;
      end else if (state_q == BUSY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (do_to) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
